// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the MIPS pipeline registers.
package mips_pipe_pkg;

  localparam int unsigned DW_DEFAULT       = 32;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3008;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] pcplus;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } stage_state_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM boundary bundle: EX-side beat with valid/ready, MEM-side beat with valid/ready, flush.
interface ex_mem_stage_if import mips_pipe_pkg::*; #(
  parameter int unsigned DW = DW_DEFAULT
) ();

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] instrE;
  logic [DW-1:0] ALUOutE;
  logic [DW-1:0] WriteDataE;
  logic [DW-1:0] pcplusE;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] instrM;
  logic [DW-1:0] ALUOutM;
  logic [DW-1:0] WriteDataM;
  logic [DW-1:0] pcplusM;

  modport master (
    output flush, in_valid, instrE, ALUOutE, WriteDataE, pcplusE, out_ready,
    input  in_ready, out_valid, instrM, ALUOutM, WriteDataM, pcplusM
  );

  modport slave (
    input  flush, in_valid, instrE, ALUOutE, WriteDataE, pcplusE, out_ready,
    output in_ready, out_valid, instrM, ALUOutM, WriteDataM, pcplusM
  );

endinterface

// File: rtl/ex_mem_stage_slot.sv
// One payload register with a valid bit; clear kills the entry but preserves the KeepMask bits.
module pipe_slot import mips_pipe_pkg::*; #(
  parameter int unsigned      Width    = 4 * DW_DEFAULT,
  parameter logic [Width-1:0] ResetVal = '0,
  parameter logic [Width-1:0] ClearVal = '0,
  parameter logic [Width-1:0] KeepMask = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic             clear,
  input  logic [Width-1:0] data_in,
  output logic             valid,
  output logic [Width-1:0] data
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= ResetVal;
    end else if (clear) begin
      valid_q <= 1'b0;
      data_q  <= (data_q & KeepMask) | (ClearVal & ~KeepMask);
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_in;
    end else if (drain) begin
      // Data stays put when emptied; MEM ignores it while invalid.
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, optional skid entry and flush-to-NOP.
module ex_mem_stage #(
  parameter int unsigned   DW        = mips_pipe_pkg::DW_DEFAULT,
  parameter logic [DW-1:0] PC_RESET  = DW'(mips_pipe_pkg::PC_RESET_DEFAULT),
  parameter logic [DW-1:0] NOP_INSTR = DW'(mips_pipe_pkg::NOP_INSTR),
  parameter bit            SKID      = 1'b1
) (
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);
  import mips_pipe_pkg::*;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] aluout;
    logic [DW-1:0] writedata;
    logic [DW-1:0] pcplus;
  } payload_t;

  localparam int unsigned     PayloadW = 4 * DW;
  localparam logic [4*DW-1:0] EmptyVal = {NOP_INSTR, {(2 * DW){1'b0}}, PC_RESET};
  // pcplus survives a flush so the exception logic can still read the EPC.
  localparam logic [4*DW-1:0] PcKeep   = {{(3 * DW){1'b0}}, {DW{1'b1}}};

  stage_state_e state_q, state_d;
  logic         in_ready_q;
  logic         main_valid, skid_valid;
  logic         in_xfer, out_xfer;
  logic         main_load, main_drain;
  payload_t     in_data, main_data, skid_data, main_next;

  assign in_data  = {bus.instrE, bus.ALUOutE, bus.WriteDataE, bus.pcplusE};
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = main_valid && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_drain = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_d   = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (SKID && in_xfer) begin
          state_d = StTwo;
        end else if (out_xfer) begin
          main_drain = 1'b1;
          state_d    = StEmpty;
        end
      end
      StTwo: begin
        if (out_xfer) begin
          main_load = 1'b1;
          state_d   = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (bus.flush) state_d = StEmpty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StTwo);
    end
  end

  // A full skid always drains into main ahead of any new beat.
  assign main_next = skid_valid ? skid_data : in_data;

  pipe_slot #(
    .Width    (PayloadW),
    .ResetVal (EmptyVal),
    .ClearVal (EmptyVal),
    .KeepMask (PcKeep)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .drain   (main_drain),
    .clear   (bus.flush),
    .data_in (main_next),
    .valid   (main_valid),
    .data    (main_data)
  );

  if (SKID) begin : g_skid
    pipe_slot #(
      .Width    (PayloadW),
      .ResetVal (EmptyVal),
      .ClearVal (EmptyVal),
      .KeepMask (PcKeep)
    ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (in_xfer && main_valid && !out_xfer),
      .drain   (out_xfer),
      .clear   (bus.flush),
      .data_in (in_data),
      .valid   (skid_valid),
      .data    (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_data  = EmptyVal;
  end

  // in_ready_q is low only in reset or with the skid full; without a skid it just marks reset.
  assign bus.in_ready   = in_ready_q && (SKID || bus.out_ready || !main_valid);
  assign bus.out_valid  = main_valid;
  assign bus.instrM     = main_data.instr;
  assign bus.ALUOutM    = main_data.aluout;
  assign bus.WriteDataM = main_data.writedata;
  assign bus.pcplusM    = main_data.pcplus;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed vector table plus hand sequences and a scoreboarded random stream for ex_mem_stage.
module tb_ex_mem_stage;
  import mips_pipe_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ex_mem_stage_if #(.DW(32)) bus1 ();
  ex_mem_stage_if #(.DW(32)) bus0 ();

  ex_mem_stage #(.DW(32), .SKID(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ex_mem_stage #(.DW(32), .SKID(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exp_ov;
    logic        exp_ir;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [31:0] instr,
                              logic [31:0] pc, logic eov, logic eir, logic [31:0] ei,
                              logic [31:0] ep);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.instr = instr; v.pc = pc;
    v.exp_ov = eov; v.exp_ir = eir; v.exp_instr = ei; v.exp_pc = ep;
    return v;
  endfunction

  function automatic logic [31:0] alu_of(logic [31:0] x);
    return x ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] wd_of(logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive1(logic iv, logic ordy, logic fl, logic [31:0] instr, logic [31:0] pc);
    bus1.in_valid   = iv;
    bus1.out_ready  = ordy;
    bus1.flush      = fl;
    bus1.instrE     = instr;
    bus1.ALUOutE    = alu_of(instr);
    bus1.WriteDataE = wd_of(instr);
    bus1.pcplusE    = pc;
  endtask

  vec_t            vecs[17];
  ex_mem_payload_t sb[$];

  initial begin
    logic [31:0]     ei;
    ex_mem_payload_t cur, exp_p;
    logic            in_x, out_x, last_in_x;
    int              sent, recv, cyc;

    vecs[0]  = mk(0, 1, 0, 32'h0,         32'h0,    0, 1, 32'h0,         32'h3008);
    vecs[1]  = mk(1, 1, 0, 32'h8C01_0004, 32'h1000, 1, 1, 32'h8C01_0004, 32'h1000);
    vecs[2]  = mk(1, 1, 0, 32'hAC02_0008, 32'h1004, 1, 1, 32'hAC02_0008, 32'h1004);
    vecs[3]  = mk(1, 1, 0, 32'h0022_1820, 32'h1008, 1, 1, 32'h0022_1820, 32'h1008);
    vecs[4]  = mk(0, 1, 0, 32'h0,         32'h0,    0, 1, 32'h0022_1820, 32'h1008);
    vecs[5]  = mk(1, 0, 0, 32'h1111_1111, 32'h2000, 1, 1, 32'h1111_1111, 32'h2000);
    vecs[6]  = mk(1, 0, 0, 32'h2222_2222, 32'h2004, 1, 0, 32'h1111_1111, 32'h2000);
    vecs[7]  = mk(1, 0, 0, 32'h3333_3333, 32'h2008, 1, 0, 32'h1111_1111, 32'h2000);
    vecs[8]  = mk(1, 1, 0, 32'h3333_3333, 32'h2008, 1, 1, 32'h2222_2222, 32'h2004);
    vecs[9]  = mk(0, 1, 0, 32'h0,         32'h0,    0, 1, 32'h2222_2222, 32'h2004);
    vecs[10] = mk(1, 0, 0, 32'h4444_4444, 32'h3010, 1, 1, 32'h4444_4444, 32'h3010);
    vecs[11] = mk(1, 0, 0, 32'h5555_5555, 32'h3014, 1, 0, 32'h4444_4444, 32'h3010);
    vecs[12] = mk(1, 0, 1, 32'h6666_6666, 32'h3018, 0, 1, 32'h0,         32'h3010);
    vecs[13] = mk(0, 1, 0, 32'h0,         32'h0,    0, 1, 32'h0,         32'h3010);
    vecs[14] = mk(1, 1, 0, 32'h7777_7777, 32'h4000, 1, 1, 32'h7777_7777, 32'h4000);
    vecs[15] = mk(1, 0, 1, 32'h8888_8888, 32'h4004, 0, 1, 32'h0,         32'h4000);
    vecs[16] = mk(0, 1, 0, 32'h0,         32'h0,    0, 1, 32'h0,         32'h4000);

    rst = 1'b1;
    drive1(0, 0, 0, 32'h0, 32'h0);
    bus0.in_valid = 0; bus0.out_ready = 0; bus0.flush = 0;
    bus0.instrE = 0; bus0.ALUOutE = 0; bus0.WriteDataE = 0; bus0.pcplusE = 0;
    #1;
    chk("reset out_valid", 32'(bus1.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus1.in_ready), 32'd0);
    chk("reset instrM", bus1.instrM, 32'h0);
    chk("reset pcplusM", bus1.pcplusM, 32'h0000_3008);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive1(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].instr, vecs[i].pc);
      @(posedge clk);
      #1;
      ei = vecs[i].exp_instr;
      chk($sformatf("vec%0d out_valid", i), 32'(bus1.out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d in_ready", i), 32'(bus1.in_ready), 32'(vecs[i].exp_ir));
      chk($sformatf("vec%0d instrM", i), bus1.instrM, ei);
      chk($sformatf("vec%0d ALUOutM", i), bus1.ALUOutM, (ei == 0) ? 32'h0 : alu_of(ei));
      chk($sformatf("vec%0d WriteDataM", i), bus1.WriteDataM, (ei == 0) ? 32'h0 : wd_of(ei));
      chk($sformatf("vec%0d pcplusM", i), bus1.pcplusM, vecs[i].exp_pc);
    end

    // Fill both entries, then reset asynchronously mid-cycle.
    @(negedge clk); drive1(1, 0, 0, 32'h9999_0001, 32'h6000);
    @(negedge clk); drive1(1, 0, 0, 32'h9999_0002, 32'h6004);
    @(negedge clk); drive1(0, 0, 0, 32'h0, 32'h0);
    chk("full out_valid", 32'(bus1.out_valid), 32'd1);
    chk("full in_ready", 32'(bus1.in_ready), 32'd0);
    chk("full instrM", bus1.instrM, 32'h9999_0001);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(bus1.out_valid), 32'd0);
    chk("midrst instrM", bus1.instrM, 32'h0);
    chk("midrst ALUOutM", bus1.ALUOutM, 32'h0);
    chk("midrst WriteDataM", bus1.WriteDataM, 32'h0);
    chk("midrst pcplusM", bus1.pcplusM, 32'h0000_3008);
    chk("midrst in_ready", 32'(bus1.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst in_ready", 32'(bus1.in_ready), 32'd1);
    chk("postrst out_valid", 32'(bus1.out_valid), 32'd0);

    // Single-entry build: in_ready follows out_ready combinationally.
    @(negedge clk);
    bus0.in_valid = 1; bus0.out_ready = 0; bus0.instrE = 32'hAAAA_0001; bus0.pcplusE = 32'h5000;
    #1;
    chk("skid0 empty in_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("skid0 load out_valid", 32'(bus0.out_valid), 32'd1);
    chk("skid0 load instrM", bus0.instrM, 32'hAAAA_0001);
    @(negedge clk);
    bus0.instrE = 32'hAAAA_0002; bus0.pcplusE = 32'h5004;
    #1;
    chk("skid0 stall in_ready", 32'(bus0.in_ready), 32'd0);
    bus0.out_ready = 1;
    #1;
    chk("skid0 ready in_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("skid0 replace instrM", bus0.instrM, 32'hAAAA_0002);
    chk("skid0 replace pcplusM", bus0.pcplusM, 32'h5004);
    chk("skid0 replace out_valid", 32'(bus0.out_valid), 32'd1);
    @(negedge clk);
    bus0.in_valid = 0;
    @(posedge clk); #1;
    chk("skid0 drain out_valid", 32'(bus0.out_valid), 32'd0);
    chk("skid0 drain instrM hold", bus0.instrM, 32'hAAAA_0002);

    // Random valid/ready stream against a scoreboard queue.
    sent = 0; recv = 0; cyc = 0; last_in_x = 0;
    cur = '0;
    drive1(0, 0, 0, 32'h0, 32'h0);
    while (recv < 2000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (last_in_x) bus1.in_valid = 1'b0;
      if (!bus1.in_valid && sent < 2000 && $urandom_range(0, 3) != 0) begin
        cur.instr = $urandom; cur.aluout = $urandom;
        cur.writedata = $urandom; cur.pcplus = $urandom;
        bus1.in_valid = 1'b1;
        bus1.instrE = cur.instr; bus1.ALUOutE = cur.aluout;
        bus1.WriteDataE = cur.writedata; bus1.pcplusE = cur.pcplus;
      end
      bus1.out_ready = ($urandom_range(0, 2) != 0);
      #4;
      in_x  = bus1.in_valid && bus1.in_ready;
      out_x = bus1.out_valid && bus1.out_ready;
      if (out_x) begin
        if (sb.size() == 0) begin
          chk("rand spurious beat", bus1.instrM, 32'hDEAD_BEEF);
          errors++;
        end else begin
          exp_p = sb.pop_front();
          chk("rand instrM", bus1.instrM, exp_p.instr);
          chk("rand ALUOutM", bus1.ALUOutM, exp_p.aluout);
          chk("rand WriteDataM", bus1.WriteDataM, exp_p.writedata);
          chk("rand pcplusM", bus1.pcplusM, exp_p.pcplus);
        end
        recv++;
      end
      if (in_x) begin
        sb.push_back(cur);
        sent++;
      end
      last_in_x = in_x;
      @(posedge clk);
    end
    chk("rand beats received", 32'(recv), 32'd2000);
    chk("rand scoreboard empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
